// File: rtl/fu_alu_pipe_if.sv
// Issue-side operands and result-side pipeline taps of the ALU functional unit.
interface fu_alu_pipe_if #(
    parameter int unsigned NUM_LANES  = 2,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned PIPE_DEPTH = 2
);
    logic                                 stall;
    logic                                 flush;
    logic [NUM_LANES-1:0]                 ex_valid;
    logic [NUM_LANES*XLEN-1:0]            ex_pc;
    logic [NUM_LANES*XLEN-1:0]            ex_rs1;
    logic [NUM_LANES*XLEN-1:0]            ex_rs2;
    logic [NUM_LANES*XLEN-1:0]            ex_imm;
    logic [2*NUM_LANES-1:0]               ex_src1_sel;
    logic [2*NUM_LANES-1:0]               ex_src2_sel;
    logic [12*NUM_LANES-1:0]              ex_op;
    logic [5*NUM_LANES-1:0]               ex_rd;
    logic [NUM_LANES-1:0]                 ex_br;
    logic [NUM_LANES*XLEN-1:0]            ex_result;
    logic [NUM_LANES-1:0]                 ex_live;
    logic [PIPE_DEPTH*NUM_LANES*XLEN-1:0] stg_result;
    logic [PIPE_DEPTH*NUM_LANES-1:0]      stg_valid;
    logic [PIPE_DEPTH*NUM_LANES*5-1:0]    stg_rd;

    modport master (
        output stall, flush, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_imm,
               ex_src1_sel, ex_src2_sel, ex_op, ex_rd, ex_br,
        input  ex_result, ex_live, stg_result, stg_valid, stg_rd
    );

    modport slave (
        input  stall, flush, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_imm,
               ex_src1_sel, ex_src2_sel, ex_op, ex_rd, ex_br,
        output ex_result, ex_live, stg_result, stg_valid, stg_rd
    );
endinterface

// File: rtl/fu_alu_pipe.sv
// N-lane integer ALU for the EX stage with a PIPE_DEPTH-deep result pipeline
// (stage 0 = MEM) carrying result, rd and valid for writeback and forwarding.
module fu_alu_pipe #(
    parameter int unsigned NUM_LANES  = 2,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned PIPE_DEPTH = 2
) (
    input logic          clk,
    input logic          rstn,
    fu_alu_pipe_if.slave bus
);
    localparam int unsigned SHW = $clog2(XLEN);

    logic [NUM_LANES-1:0][XLEN-1:0] ex_res;
    logic [NUM_LANES-1:0]           br_eff;
    logic [NUM_LANES-1:0]           live;
    logic [NUM_LANES-1:0]           cap_valid;
    logic [NUM_LANES-1:0][XLEN-1:0] cap_result;
    logic [NUM_LANES-1:0][4:0]      cap_rd;

    logic [PIPE_DEPTH-1:0][NUM_LANES-1:0][XLEN-1:0] stg_result_q;
    logic [PIPE_DEPTH-1:0][NUM_LANES-1:0]           stg_valid_q;
    logic [PIPE_DEPTH-1:0][NUM_LANES-1:0][4:0]      stg_rd_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [1:0]      sel1;
        logic [1:0]      sel2;
        logic [11:0]     op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] r;
        logic [SHW-1:0]  shamt;

        assign sel1  = bus.ex_src1_sel[2*i +: 2];
        assign sel2  = bus.ex_src2_sel[2*i +: 2];
        assign op    = bus.ex_op[12*i +: 12];
        assign shamt = b[SHW-1:0];

        // Operand muxes and one-hot ALU; anything but exactly one op bit yields 0
        always_comb begin
            a = '0;
            b = '0;
            r = '0;
            unique case (sel1)
                2'b00:   a = bus.ex_pc[XLEN*i +: XLEN];
                2'b01:   a = bus.ex_rs1[XLEN*i +: XLEN];
                default: a = '0;
            endcase
            unique case (sel2)
                2'b00:   b = bus.ex_imm[XLEN*i +: XLEN];
                2'b01:   b = bus.ex_rs2[XLEN*i +: XLEN];
                2'b10:   b = XLEN'(4);
                default: b = '0;
            endcase
            unique case (op)
                12'h001: r = a + b;
                12'h002: r = a - b;
                12'h004: r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
                12'h008: r = {{(XLEN-1){1'b0}}, a < b};
                12'h010: r = a & b;
                12'h020: r = a | b;
                12'h040: r = ~(a | b);
                12'h080: r = a ^ b;
                12'h100: r = a << shamt;
                12'h200: r = a >> shamt;
                12'h400: r = $signed(a) >>> shamt;
                12'h800: r = b;
                default: r = '0;
            endcase
        end

        assign ex_res[i] = r;
    end

    assign br_eff = bus.ex_br & bus.ex_valid;

    // A lane survives only if no older valid lane redirects; its own branch does not count
    always_comb begin
        live = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            logic older_br;
            older_br = 1'b0;
            for (int unsigned j = 0; j < i; j++) begin
                older_br = older_br | br_eff[j];
            end
            live[i] = bus.ex_valid[i] & ~older_br;
        end
    end

    // Stage-0 capture: dead lanes become an all-zero bubble rather than a stale value
    always_comb begin
        cap_valid  = '0;
        cap_result = '0;
        cap_rd     = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            cap_valid[i]  = live[i];
            cap_result[i] = live[i] ? ex_res[i] : '0;
            cap_rd[i]     = live[i] ? bus.ex_rd[5*i +: 5] : 5'd0;
        end
    end

    // Result pipeline: async reset, then flush over stall over shift
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stg_result_q <= '0;
            stg_valid_q  <= '0;
            stg_rd_q     <= '0;
        end else if (bus.flush) begin
            stg_result_q <= '0;
            stg_valid_q  <= '0;
            stg_rd_q     <= '0;
        end else if (!bus.stall) begin
            stg_result_q[0] <= cap_result;
            stg_valid_q[0]  <= cap_valid;
            stg_rd_q[0]     <= cap_rd;
            for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
                stg_result_q[k] <= stg_result_q[k-1];
                stg_valid_q[k]  <= stg_valid_q[k-1];
                stg_rd_q[k]     <= stg_rd_q[k-1];
            end
        end
    end

    assign bus.ex_result  = ex_res;
    assign bus.ex_live    = live;
    assign bus.stg_result = stg_result_q;
    assign bus.stg_valid  = stg_valid_q;
    assign bus.stg_rd     = stg_rd_q;
endmodule

// File: tb/tb_fu_alu_pipe.sv
// Bench for fu_alu_pipe: a 2-lane/2-stage and a 4-lane/3-stage instance share one
// stimulus stream (the 2-lane unit sees lanes 0..1) and one reference model.
module tb_fu_alu_pipe;
    localparam int unsigned L = 4;
    localparam int unsigned D = 3;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    fu_alu_pipe_if #(.NUM_LANES(2), .XLEN(32), .PIPE_DEPTH(2)) if2 ();
    fu_alu_pipe_if #(.NUM_LANES(4), .XLEN(32), .PIPE_DEPTH(3)) if4 ();

    fu_alu_pipe #(.NUM_LANES(2), .XLEN(32), .PIPE_DEPTH(2)) u_dut2 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if2)
    );
    fu_alu_pipe #(.NUM_LANES(4), .XLEN(32), .PIPE_DEPTH(3)) u_dut4 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if4)
    );

    assign if2.stall       = if4.stall;
    assign if2.flush       = if4.flush;
    assign if2.ex_valid    = if4.ex_valid[1:0];
    assign if2.ex_pc       = if4.ex_pc[63:0];
    assign if2.ex_rs1      = if4.ex_rs1[63:0];
    assign if2.ex_rs2      = if4.ex_rs2[63:0];
    assign if2.ex_imm      = if4.ex_imm[63:0];
    assign if2.ex_src1_sel = if4.ex_src1_sel[3:0];
    assign if2.ex_src2_sel = if4.ex_src2_sel[3:0];
    assign if2.ex_op       = if4.ex_op[23:0];
    assign if2.ex_rd       = if4.ex_rd[9:0];
    assign if2.ex_br       = if4.ex_br[1:0];

    // Stimulus per lane
    logic [3:0]  t_valid;
    logic [3:0]  t_br;
    logic [1:0]  t_s1  [L];
    logic [1:0]  t_s2  [L];
    logic [11:0] t_op  [L];
    logic [4:0]  t_rd  [L];
    logic [31:0] t_pc  [L];
    logic [31:0] t_rs1 [L];
    logic [31:0] t_rs2 [L];
    logic [31:0] t_imm [L];

    // Reference model state
    logic        m_v [D][L];
    logic [31:0] m_r [D][L];
    logic [4:0]  m_d [D][L];
    logic [3:0]  c_live;
    logic [31:0] c_res [L];

    int n_tests;
    int n_fail;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [1:0] s1, input logic [1:0] s2,
                                            input logic [11:0] op, input logic [31:0] pc,
                                            input logic [31:0] rs1, input logic [31:0] rs2,
                                            input logic [31:0] imm);
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] w;
        int          sh;
        a = (s1 == 2'b00) ? pc : (s1 == 2'b01) ? rs1 : 32'd0;
        b = (s2 == 2'b00) ? imm : (s2 == 2'b01) ? rs2 : (s2 == 2'b10) ? 32'd4 : 32'd0;
        sh = int'(b[4:0]);
        if ($countones(op) != 1) return 32'd0;
        if (op[0]) return a + b;
        if (op[1]) return a - b;
        if (op[2]) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        if (op[3]) return (a < b) ? 32'd1 : 32'd0;
        if (op[4]) return a & b;
        if (op[5]) return a | b;
        if (op[6]) return ~(a | b);
        if (op[7]) return a ^ b;
        if (op[8]) return a << sh;
        if (op[9]) return a >> sh;
        if (op[10]) begin
            w = {{32{a[31]}}, a};
            w = w >> sh;
            return w[31:0];
        end
        return b;
    endfunction

    function automatic logic [3:0] ref_live(input logic [3:0] v, input logic [3:0] br);
        logic [3:0] l;
        l = v;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < i; j++)
                if (v[j] && br[j]) l[i] = 1'b0;
        return l;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic clear_model();
        for (int k = 0; k < D; k++)
            for (int i = 0; i < L; i++) begin
                m_v[k][i] = 1'b0;
                m_r[k][i] = 32'd0;
                m_d[k][i] = 5'd0;
            end
    endtask

    task automatic clear_stim();
        t_valid = 4'b0;
        t_br    = 4'b0;
        for (int i = 0; i < L; i++) begin
            t_s1[i] = 2'b11; t_s2[i] = 2'b11; t_op[i] = 12'h001; t_rd[i] = 5'd0;
            t_pc[i] = 32'd0; t_rs1[i] = 32'd0; t_rs2[i] = 32'd0; t_imm[i] = 32'd0;
        end
    endtask

    task automatic rand_stim();
        t_valid = 4'($urandom);
        t_br    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
        for (int i = 0; i < L; i++) begin
            t_s1[i]  = 2'($urandom);
            t_s2[i]  = 2'($urandom);
            t_op[i]  = ($urandom_range(0, 9) == 0) ? 12'($urandom)
                                                   : 12'd1 << $urandom_range(0, 11);
            t_rd[i]  = 5'($urandom);
            t_pc[i]  = pick();
            t_rs1[i] = pick();
            t_rs2[i] = pick();
            t_imm[i] = pick();
        end
    endtask

    task automatic set_lane(input int i, input logic [11:0] op, input logic [1:0] s1,
                            input logic [1:0] s2, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic [31:0] imm,
                            input logic [4:0] rd);
        t_op[i] = op; t_s1[i] = s1; t_s2[i] = s2;
        t_rs1[i] = rs1; t_rs2[i] = rs2; t_imm[i] = imm; t_rd[i] = rd;
    endtask

    // Drive stimulus and check the combinational EX outputs against the model
    task automatic drive();
        for (int i = 0; i < L; i++) begin
            if4.ex_pc[i*32 +: 32]      = t_pc[i];
            if4.ex_rs1[i*32 +: 32]     = t_rs1[i];
            if4.ex_rs2[i*32 +: 32]     = t_rs2[i];
            if4.ex_imm[i*32 +: 32]     = t_imm[i];
            if4.ex_src1_sel[i*2 +: 2]  = t_s1[i];
            if4.ex_src2_sel[i*2 +: 2]  = t_s2[i];
            if4.ex_op[i*12 +: 12]      = t_op[i];
            if4.ex_rd[i*5 +: 5]        = t_rd[i];
        end
        if4.ex_valid = t_valid;
        if4.ex_br    = t_br;
        #1;
        c_live = ref_live(t_valid, t_br);
        for (int i = 0; i < L; i++) begin
            c_res[i] = ref_alu(t_s1[i], t_s2[i], t_op[i], t_pc[i], t_rs1[i], t_rs2[i], t_imm[i]);
            check_eq($sformatf("d4 ex_result lane%0d", i), 64'(if4.ex_result[i*32 +: 32]),
                     64'(c_res[i]));
        end
        for (int i = 0; i < 2; i++)
            check_eq($sformatf("d2 ex_result lane%0d", i), 64'(if2.ex_result[i*32 +: 32]),
                     64'(c_res[i]));
        check_eq("d4 ex_live", 64'(if4.ex_live), 64'(c_live));
        check_eq("d2 ex_live", 64'(if2.ex_live), 64'(c_live[1:0]));
    endtask

    task automatic check_stages();
        for (int k = 0; k < D; k++)
            for (int i = 0; i < L; i++) begin
                check_eq($sformatf("d4 stg%0d lane%0d valid", k, i),
                         64'(if4.stg_valid[k*L+i]), 64'(m_v[k][i]));
                check_eq($sformatf("d4 stg%0d lane%0d result", k, i),
                         64'(if4.stg_result[(k*L+i)*32 +: 32]), 64'(m_r[k][i]));
                check_eq($sformatf("d4 stg%0d lane%0d rd", k, i),
                         64'(if4.stg_rd[(k*L+i)*5 +: 5]), 64'(m_d[k][i]));
            end
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 2; i++) begin
                check_eq($sformatf("d2 stg%0d lane%0d valid", k, i),
                         64'(if2.stg_valid[k*2+i]), 64'(m_v[k][i]));
                check_eq($sformatf("d2 stg%0d lane%0d result", k, i),
                         64'(if2.stg_result[(k*2+i)*32 +: 32]), 64'(m_r[k][i]));
                check_eq($sformatf("d2 stg%0d lane%0d rd", k, i),
                         64'(if2.stg_rd[(k*2+i)*5 +: 5]), 64'(m_d[k][i]));
            end
    endtask

    // Advance one clock, update the model by the stage rules, check all stages
    task automatic clock();
        @(posedge clk);
        if (!rstn || if4.flush) begin
            clear_model();
        end else if (!if4.stall) begin
            for (int k = D - 1; k >= 1; k--)
                for (int i = 0; i < L; i++) begin
                    m_v[k][i] = m_v[k-1][i];
                    m_r[k][i] = m_r[k-1][i];
                    m_d[k][i] = m_d[k-1][i];
                end
            for (int i = 0; i < L; i++) begin
                m_v[0][i] = c_live[i];
                m_r[0][i] = c_live[i] ? c_res[i] : 32'd0;
                m_d[0][i] = c_live[i] ? t_rd[i] : 5'd0;
            end
        end
        #1;
        check_stages();
    endtask

    task automatic step();
        drive();
        clock();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn = 1'b0;
        if4.stall = 1'b0;
        if4.flush = 1'b0;
        clear_model();
        clear_stim();
        @(posedge clk);
        #1;

        // Reset held with inputs toggling
        repeat (4) begin
            rand_stim();
            step();
        end
        rstn = 1'b1;
        clear_stim();
        step();
        check_eq("post-reset d2 stg_valid", 64'(if2.stg_valid), 64'd0);

        // SUB and SRA through both stages
        clear_stim();
        t_valid = 4'b0011;
        set_lane(0, 12'h002, 2'b01, 2'b01, 32'd5, 32'd7, 32'd0, 5'd3);
        set_lane(1, 12'h400, 2'b01, 2'b00, 32'h8000_0000, 32'd0, 32'd4, 5'd9);
        drive();
        check_eq("sub ex_result", 64'(if2.ex_result[31:0]), 64'hFFFF_FFFE);
        check_eq("sra ex_result", 64'(if2.ex_result[63:32]), 64'hF800_0000);
        clock();
        check_eq("sub stg0", 64'(if2.stg_result[31:0]), 64'hFFFF_FFFE);
        check_eq("sra stg0", 64'(if2.stg_result[63:32]), 64'hF800_0000);
        clear_stim();
        step();
        check_eq("sub stg1", 64'(if2.stg_result[95:64]), 64'hFFFF_FFFE);
        check_eq("sra stg1", 64'(if2.stg_result[127:96]), 64'hF800_0000);

        // SLT / SLTU of -1 vs 1
        clear_stim();
        t_valid = 4'b0011;
        set_lane(0, 12'h004, 2'b01, 2'b01, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd1);
        set_lane(1, 12'h008, 2'b01, 2'b01, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd2);
        drive();
        check_eq("slt -1<1", 64'(if2.ex_result[31:0]), 64'd1);
        check_eq("sltu -1<1", 64'(if2.ex_result[63:32]), 64'd0);
        clock();

        // Younger-lane kill
        clear_stim();
        t_valid = 4'b0011;
        t_br    = 4'b0001;
        set_lane(0, 12'h001, 2'b01, 2'b11, 32'h33, 32'd0, 32'd0, 5'd4);
        set_lane(1, 12'h001, 2'b01, 2'b11, 32'h55, 32'd0, 32'd0, 5'd5);
        drive();
        check_eq("kill ex_live", 64'(if2.ex_live), 64'b01);
        clock();
        check_eq("kill lane1 valid", 64'(if2.stg_valid[1]), 64'd0);
        check_eq("kill lane1 result", 64'(if2.stg_result[63:32]), 64'd0);
        check_eq("kill lane1 rd", 64'(if2.stg_rd[9:5]), 64'd0);
        check_eq("kill lane0 kept", 64'(if2.stg_valid[0]), 64'd1);
        t_br = 4'b0010;
        drive();
        check_eq("own br ex_live", 64'(if2.ex_live), 64'b11);
        clock();

        // Stall holds stages while inputs change
        clear_stim();
        t_valid = 4'b0011;
        set_lane(0, 12'h001, 2'b01, 2'b11, 32'h11, 32'd0, 32'd0, 5'd6);
        set_lane(1, 12'h001, 2'b01, 2'b11, 32'h22, 32'd0, 32'd0, 5'd7);
        step();
        if4.stall = 1'b1;
        repeat (3) begin
            rand_stim();
            step();
        end
        check_eq("stall stg0 lane0", 64'(if2.stg_result[31:0]), 64'h11);
        check_eq("stall stg0 lane1", 64'(if2.stg_result[63:32]), 64'h22);
        if4.stall = 1'b0;
        clear_stim();
        step();
        check_eq("resume stg1 lane0", 64'(if2.stg_result[95:64]), 64'h11);
        check_eq("resume stg1 lane1", 64'(if2.stg_result[127:96]), 64'h22);

        // Flush wins over stall
        repeat (3) begin
            rand_stim();
            t_valid = 4'hF;
            t_br    = 4'h0;
            step();
        end
        if4.stall = 1'b1;
        if4.flush = 1'b1;
        rand_stim();
        step();
        check_eq("flush d4 stg_valid", 64'(if4.stg_valid), 64'd0);
        check_eq("flush d4 stg_result lane0", 64'(if4.stg_result[31:0]), 64'd0);
        if4.stall = 1'b0;
        if4.flush = 1'b0;

        // Four lanes, three stages
        clear_stim();
        t_valid = 4'hF;
        t_br    = 4'b0010;
        set_lane(0, 12'h001, 2'b01, 2'b00, 32'd3, 32'd0, 32'd4, 5'd8);
        set_lane(2, 12'h003, 2'b01, 2'b01, 32'd9, 32'd9, 32'd0, 5'd10);
        drive();
        check_eq("d4 lane1 br ex_live", 64'(if4.ex_live), 64'b0011);
        check_eq("d4 invalid op", 64'(if4.ex_result[95:64]), 64'd0);
        clock();
        clear_stim();
        step();
        step();
        check_eq("d4 stg2 lane0 result", 64'(if4.stg_result[(2*L)*32 +: 32]), 64'd7);
        check_eq("d4 stg2 lane0 valid", 64'(if4.stg_valid[2*L]), 64'd1);

        // Random traffic with occasional stall and flush
        repeat (600) begin
            rand_stim();
            if4.stall = ($urandom_range(0, 4) == 0);
            if4.flush = ($urandom_range(0, 19) == 0);
            step();
        end
        if4.stall = 1'b0;
        if4.flush = 1'b0;

        // Reset asserted between clock edges
        repeat (4) begin
            rand_stim();
            t_valid = 4'hF;
            t_br    = 4'h0;
            step();
        end
        #2;
        rstn = 1'b0;
        clear_model();
        #1;
        check_stages();
        @(posedge clk);
        #1;
        check_stages();
        rstn = 1'b1;
        repeat (50) begin
            rand_stim();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
